// File: rtl/keyed_lock_array_if.sv
// rtl/keyed_lock_array_if.sv - key-load handshake and data-path bundle for keyed_lock_array
interface keyed_lock_array_if #(
    parameter int N_BITS    = 32,
    parameter int KEY_CHUNK = 8,
    parameter int EPOCH_W   = 4
);
    logic                 key_valid;
    logic                 key_ready;
    logic [KEY_CHUNK-1:0] key_chunk;
    logic                 key_clear;
    logic                 key_loaded;
    logic [EPOCH_W-1:0]   key_epoch;
    logic                 in_valid;
    logic [N_BITS-1:0]    data_in;
    logic [N_BITS-1:0]    alt_in;
    logic                 out_valid;
    logic [N_BITS-1:0]    data_out;

    modport master (
        output key_valid, key_chunk, key_clear, in_valid, data_in, alt_in,
        input  key_ready, key_loaded, key_epoch, out_valid, data_out
    );

    modport slave (
        input  key_valid, key_chunk, key_clear, in_valid, data_in, alt_in,
        output key_ready, key_loaded, key_epoch, out_valid, data_out
    );
endinterface

// File: rtl/keyed_lock_array.sv
// rtl/keyed_lock_array.sv - serially keyed XOR/XNOR/MUX lock gates with registered data path
module keyed_lock_array #(
    parameter int              N_BITS    = 32,
    parameter int              KEY_CHUNK = 8,
    parameter logic [N_BITS-1:0] MUX_MASK = '0,
    parameter logic [N_BITS-1:0] INV_MASK = '0,
    parameter int              EPOCH_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    keyed_lock_array_if.slave bus
);
    localparam int BEATS = N_BITS / KEY_CHUNK;
    localparam int CNT_W = $clog2(BEATS + 1);

    if ((N_BITS % KEY_CHUNK) != 0 || KEY_CHUNK > N_BITS) begin : g_bad_params
        $error("keyed_lock_array: N_BITS must be a non-zero multiple of KEY_CHUNK");
    end

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    beat_cnt;
    logic [N_BITS-1:0]   shadow;
    logic [N_BITS-1:0]   active;
    logic [N_BITS-1:0]   gated;
    logic                beat;
    logic                last_beat;
    logic                key_loaded;
    logic [EPOCH_W-1:0]  key_epoch;
    logic                out_valid;
    logic [N_BITS-1:0]   data_out;

    // key_clear blocks acceptance in every state; COMMIT never accepts.
    assign bus.key_ready = (state != COMMIT) && !bus.key_clear;
    assign beat          = bus.key_valid && bus.key_ready;
    assign last_beat     = (beat_cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (beat) state_next = last_beat ? COMMIT : LOAD;
            end
            LOAD: begin
                if (bus.key_clear)          state_next = IDLE;
                else if (beat && last_beat) state_next = COMMIT;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            shadow     <= '0;
            active     <= '0;
            key_loaded <= 1'b0;
            key_epoch  <= '0;
        end else begin
            state <= state_next;
            if (state == COMMIT) begin
                active     <= shadow;
                key_loaded <= 1'b1;
                key_epoch  <= key_epoch + EPOCH_W'(1);
                beat_cnt   <= '0;
            end else if (bus.key_clear) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                for (int c = 0; c < BEATS; c++) begin
                    if (beat_cnt == CNT_W'(c))
                        shadow[c*KEY_CHUNK +: KEY_CHUNK] <= bus.key_chunk;
                end
            end
        end
    end

    // MUX positions pick alt_in when the key bit is set; others XOR with key and fixed inversion.
    assign gated = (MUX_MASK & ((active & bus.alt_in) | (~active & bus.data_in)))
                 | (~MUX_MASK & (bus.data_in ^ active ^ INV_MASK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= bus.in_valid;
            if (bus.in_valid) data_out <= gated;
        end
    end

    assign bus.key_loaded = key_loaded;
    assign bus.key_epoch  = key_epoch;
    assign bus.out_valid  = out_valid;
    assign bus.data_out   = data_out;
endmodule

// File: tb/tb_keyed_lock_array.sv
// tb/tb_keyed_lock_array.sv - randomized and directed checks of keyed_lock_array against a reference model
module tb_keyed_lock_array;
    localparam int         N   = 8;
    localparam int         KC  = 4;
    localparam int         EW  = 4;
    localparam logic [7:0] MUX = 8'hC0;
    localparam logic [7:0] INV = 8'h0F;
    localparam int         NB  = N / KC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keyed_lock_array_if #(.N_BITS(N), .KEY_CHUNK(KC), .EPOCH_W(EW)) bus ();

    keyed_lock_array #(
        .N_BITS(N), .KEY_CHUNK(KC), .MUX_MASK(MUX), .INV_MASK(INV), .EPOCH_W(EW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: a list of collected chunks plus a pending-commit flag.
    logic [N-1:0]  m_active, m_partial, m_data;
    int            m_cnt;
    bit            m_commit, m_loaded, m_out_valid;
    int            m_epoch;

    function automatic logic [N-1:0] gate(input logic [N-1:0] k, input logic [N-1:0] d,
                                          input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (MUX[i]) r[i] = k[i] ? a[i] : d[i];
            else        r[i] = d[i] ^ k[i] ^ INV[i];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active    <= '0;
            m_partial   <= '0;
            m_data      <= '0;
            m_cnt       <= 0;
            m_commit    <= 1'b0;
            m_loaded    <= 1'b0;
            m_out_valid <= 1'b0;
            m_epoch     <= 0;
        end else begin
            m_out_valid <= bus.in_valid;
            if (bus.in_valid) m_data <= gate(m_active, bus.data_in, bus.alt_in);
            if (m_commit) begin
                m_active <= m_partial;
                m_loaded <= 1'b1;
                m_epoch  <= (m_epoch + 1) % (1 << EW);
                m_commit <= 1'b0;
                m_cnt    <= 0;
            end else if (bus.key_clear) begin
                m_cnt <= 0;
            end else if (bus.key_valid) begin
                m_partial[m_cnt*KC +: KC] <= bus.key_chunk;
                if (m_cnt + 1 == NB) m_commit <= 1'b1;
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_key_ready", 32'(bus.key_ready), 32'(!m_commit && !bus.key_clear));
            chk("cmp_key_loaded", 32'(bus.key_loaded), 32'(m_loaded));
            chk("cmp_key_epoch", 32'(bus.key_epoch), 32'(m_epoch));
            chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_out_valid));
            chk("cmp_data_out", 32'(bus.data_out), 32'(m_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_key(input logic [7:0] k);
        bus.key_valid = 1'b1;
        bus.key_chunk = k[3:0];
        step();
        bus.key_chunk = k[7:4];
        step();
        bus.key_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_chunk = '0;
        bus.key_clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.alt_in    = '0;
        step();
        step();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("rst_key_ready", 32'(bus.key_ready), 32'd1);
        chk("rst_key_loaded", 32'(bus.key_loaded), 32'd0);
        chk("rst_key_epoch", 32'(bus.key_epoch), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'h0);

        bus.in_valid = 1'b1;
        bus.data_in  = 8'h3C;
        bus.alt_in   = 8'hFF;
        step();
        chk("zero_key_out_valid", 32'(bus.out_valid), 32'd1);
        chk("zero_key_data", 32'(bus.data_out), 32'h33);

        bus.key_valid = 1'b1;
        bus.key_chunk = 4'h5;
        step();
        bus.key_chunk = 4'hA;
        step();
        bus.key_valid = 1'b0;
        #1;
        chk("commit_ready_low", 32'(bus.key_ready), 32'd0);
        chk("pre_commit_data", 32'(bus.data_out), 32'h33);
        step();
        chk("commit_edge_old_key", 32'(bus.data_out), 32'h33);
        chk("commit_loaded", 32'(bus.key_loaded), 32'd1);
        chk("commit_epoch", 32'(bus.key_epoch), 32'd1);
        step();
        chk("new_key_data", 32'(bus.data_out), 32'h96);

        bus.key_valid = 1'b1;
        bus.key_chunk = 4'hF;
        step();
        bus.key_clear = 1'b1;
        bus.key_chunk = 4'h0;
        #1;
        chk("clear_ready_low", 32'(bus.key_ready), 32'd0);
        step();
        bus.key_clear = 1'b0;
        bus.key_valid = 1'b0;
        step();
        chk("clear_epoch_kept", 32'(bus.key_epoch), 32'd1);
        chk("clear_data_kept", 32'(bus.data_out), 32'h96);
        bus.key_valid = 1'b1;
        bus.key_chunk = 4'h5;
        step();
        chk("clear_fresh_beat1", 32'(bus.key_ready), 32'd1);
        bus.key_chunk = 4'hA;
        step();
        chk("clear_fresh_beat2", 32'(bus.key_ready), 32'd0);
        bus.key_valid = 1'b0;
        step();
        chk("clear_reload_epoch", 32'(bus.key_epoch), 32'd2);

        for (int i = 0; i < 13; i++) load_key(8'($urandom));
        chk("epoch_15", 32'(bus.key_epoch), 32'd15);
        load_key(8'($urandom));
        chk("epoch_wrap", 32'(bus.key_epoch), 32'd0);
        chk("wrap_loaded", 32'(bus.key_loaded), 32'd1);

        for (int i = 0; i < 400; i++) begin
            bus.key_valid = 1'($urandom_range(0, 1));
            bus.key_chunk = 4'($urandom);
            bus.key_clear = ($urandom_range(0, 7) == 0);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.data_in   = 8'($urandom);
            bus.alt_in    = 8'($urandom);
            step();
        end
        bus.key_valid = 1'b0;
        bus.key_clear = 1'b0;
        step();
        step();

        bus.key_valid = 1'b1;
        bus.key_chunk = 4'h3;
        step();
        bus.key_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_epoch", 32'(bus.key_epoch), 32'd0);
        chk("midrst_loaded", 32'(bus.key_loaded), 32'd0);
        chk("midrst_data", 32'(bus.data_out), 32'h0);
        chk("midrst_ready", 32'(bus.key_ready), 32'd1);
        step();
        rst_n = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_chunk = 4'h9;
        step();
        chk("postrst_beat1", 32'(bus.key_ready), 32'd1);
        bus.key_chunk = 4'h6;
        step();
        chk("postrst_beat2", 32'(bus.key_ready), 32'd0);
        bus.key_valid = 1'b0;
        bus.data_in   = 8'h3C;
        bus.alt_in    = 8'hFF;
        bus.in_valid  = 1'b1;
        step();
        chk("postrst_epoch", 32'(bus.key_epoch), 32'd1);
        step();
        chk("postrst_data", 32'(bus.data_out), 32'(gate(8'h69, 8'h3C, 8'hFF)));
        step();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keyed_lock_array.md
Name: keyed_lock_array

Overview:
- Parametrised, sequential successor to our flat key-gate netlists.
- Applies an N-bit key to N data bits through per-bit key gates. Each bit is either an XOR/XNOR gate or a MUX gate, chosen by parameter.
- The key is loaded serially in chunks over a valid/ready handshake into a shadow register, then committed atomically.
- Data passes through a one-stage registered pipeline, which lets SAT-simulator benches swap keys mid-stream without glitching outputs.

Parameters:
- N_BITS, 32: key width = data width; must be a multiple of KEY_CHUNK.
- KEY_CHUNK, 8: key bits accepted per load beat.
- MUX_MASK, 0: bit i=1 makes bit i a MUX key gate; 0 makes it an XOR/XNOR gate.
- INV_MASK, 0: for XOR positions, bit i=1 makes the gate XNOR (extra inversion); ignored at MUX positions.
- EPOCH_W, 4: width of the key-commit counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key chunk present.
- key_ready  out  1  block accepts a chunk this cycle.
- key_chunk  in  KEY_CHUNK  key bits, least-significant chunk first.
- key_clear  in  1  abort a partial load.
- key_loaded  out  1  at least one key committed since reset.
- key_epoch  out  EPOCH_W  count of commits, wraps.
- in_valid  in  1  data qualifier.
- data_in  in  N_BITS  primary data.
- alt_in  in  N_BITS  alternate data used by MUX gates.
- out_valid  out  1  in_valid delayed one cycle.
- data_out  out  N_BITS  locked/unlocked result.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - shadow key = 0, active key = 0, beat count = 0, state IDLE.
  - key_ready=1, key_loaded=0, key_epoch=0, out_valid=0, data_out=0.
- Key-gate function, per bit i, using the active key K:
  - MUX_MASK[i]=1: out_i = K[i] ? alt_in[i] : data_in[i].
  - Otherwise: out_i = data_in[i] ^ K[i] ^ INV_MASK[i].
- Data pipeline:
  - On every edge: out_valid <= in_valid.
  - When in_valid=1: data_out <= gate function.
  - When in_valid=0: data_out holds its value.
  - Latency is exactly 1 cycle; there is no backpressure.
- FSM, 3 states:
  - IDLE:
    - key_ready=1.
    - A beat (key_valid & key_ready) writes key_chunk to shadow[KEY_CHUNK-1:0], sets beat count=1, goes to LOAD.
    - If N_BITS==KEY_CHUNK it goes straight to COMMIT.
  - LOAD:
    - key_ready=1.
    - Each beat writes shadow chunk[beat count] and increments the count.
    - The beat that fills the last chunk goes to COMMIT.
    - Cycles without key_valid hold state.
  - COMMIT (one cycle):
    - key_ready=0.
    - On the exiting edge: active key <= shadow, key_loaded <= 1, key_epoch <= key_epoch+1 (wraps at 2^EPOCH_W), beat count <= 0, next state IDLE.
- key_clear:
  - In LOAD: discards the partial load (beat count=0, shadow unchanged but unused), returns to IDLE. It takes priority over a simultaneous beat, which is not accepted; key_ready is forced 0 while key_clear=1.
  - In IDLE: no-op, and no beat is accepted that cycle.
  - In COMMIT: ignored; the commit completes.
- Key switch boundary:
  - Data sampled on the COMMIT exit edge uses the OLD active key.
  - Data sampled on the next edge uses the new key.
  - The active key never changes except on a commit, so a partial load never affects data_out.
- Back-to-back loads: a new load may begin the cycle after COMMIT. Minimum commit period is N_BITS/KEY_CHUNK + 1 cycles.
- Reset mid-load or mid-commit: all state returns to reset values immediately, and no commit occurs.
- Elaboration error if N_BITS % KEY_CHUNK != 0 or KEY_CHUNK > N_BITS.

Test Plan (N_BITS=8, KEY_CHUNK=4, MUX_MASK=8'hC0, INV_MASK=8'h0F, EPOCH_W=4):
- Reset, then in_valid=1, data_in=8'h3C, alt_in=8'hFF -> next cycle out_valid=1, data_out=8'h33, key_loaded=0, key_epoch=0.
- Beats 4'h5 then 4'hA -> COMMIT one cycle with key_ready=0. Afterwards key_loaded=1, key_epoch=1. data_in=8'h3C, alt_in=8'hFF -> data_out=8'h96.
- Data held at 8'h3C continuously during the 8'hA5 load -> data_out=8'h33 through the COMMIT exit edge, 8'h96 from the following sample onward.
- Beat 4'hF, then key_clear=1 with key_valid=1 and key_chunk=4'h0 -> no beat accepted, state IDLE, key_epoch unchanged, data_out unchanged for the same data.
- 16 consecutive full loads -> key_epoch wraps 15 -> 0; key_loaded stays 1.
- rst_n asserted after the first beat of a load -> immediately key_epoch=0, key_loaded=0, data_out=0, key_ready=1; the next load needs 2 fresh beats.
